// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default bit timing and frame geometry.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StStart = START,
        StData  = DATA,
        StStop  = STOP
    } uart_state_e;

    // 50 MHz / 115200 baud; the baud divider uses the same constant.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_DATA_BITS    = 8;

    function automatic int unsigned frame_bits(input int unsigned data_bits);
        return data_bits + 2;
    endfunction

    localparam int unsigned FRAME_BITS = frame_bits(DEFAULT_DATA_BITS);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled by an internal bit-period counter, mid-bit sampling,
// one-cycle valid / frame-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [1:0]           settle_q;
    logic                 rx_s;
    logic                 rx_d;
    logic                 start_edge;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(i_clk),
        .rst(i_rst),
        .d  (i_rx),
        .q  (rx_s)
    );

    // rx_d stays low until rx_s carries the real line rather than the synchroniser's reset
    // value, so a line held low across reset never looks like a falling edge.
    assign start_edge = rx_d & ~rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            settle_q    <= '0;
            rx_d        <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            settle_q    <= {settle_q[0], 1'b1};
            rx_d        <= settle_q[1] & rx_s;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;

            if (!i_enable) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                bit_idx_q <= '0;
                o_busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_edge) begin
                            state_q <= StStart;
                            cnt_q   <= '0;
                            o_busy  <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (cnt_q == HALF_LAST) begin
                            cnt_q <= '0;
                            if (!rx_s) begin
                                state_q   <= StData;
                                bit_idx_q <= '0;
                            end else begin
                                state_q <= StIdle;
                                o_busy  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StData: begin
                        if (cnt_q == FULL_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            if (bit_idx_q == LAST_BIT) begin
                                state_q <= StStop;
                            end else begin
                                bit_idx_q <= bit_idx_q + BIT_W'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StStop: begin
                        if (cnt_q == FULL_LAST) begin
                            // Leave at mid-stop so a start bit right after it is still caught.
                            cnt_q   <= '0;
                            state_q <= StIdle;
                            o_busy  <= 1'b0;
                            if (rx_s) begin
                                o_data  <= shift_q;
                                o_valid <= 1'b1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
